// File: rtl/mem_ir_interface.sv
// Memory/IR bridge: turns the control FSM's IoD/MemR/MemW/IRWrite strobes into one
// req/ack bus transaction, stalls the FSM until it completes, and owns IR and MDR.
module mem_ir_interface #(
  parameter int                DATA_W   = 16,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] IR_RESET = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IoD,
  input  logic              MemR,
  input  logic              MemW,
  input  logic              IRWrite,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] MDR,
  output logic [6:0]        input_control,
  output logic              Stall,
  output logic              bus_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        fetch;
  logic        cmd;
  logic        timeout_hit;
  logic [DATA_W-1:0] addr;

  assign cmd           = IRWrite | MemR | MemW;
  assign addr          = IoD ? ALUOut : PC;
  // An ack arriving on the final allowed cycle takes priority over the timeout.
  assign timeout_hit   = !mem_ack && (cnt == 8'(TIMEOUT - 1));
  assign input_control = {IR[15:12], IR[2:0]};

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    case (state)
      IDLE: begin
        Stall = cmd;
        if (cmd) state_nxt = MemW ? WR_WAIT : RD_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        Stall = 1'b1;
        if (mem_ack || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      fetch     <= 1'b0;
      cnt       <= '0;
      IR        <= IR_RESET;
      MDR       <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd) begin
            mem_req   <= 1'b1;
            mem_we    <= MemW;
            mem_addr  <= addr;
            mem_wdata <= WriteData;
            fetch     <= IRWrite;
            cnt       <= '0;
            // A write combined with any read is carried out as a plain write but flagged.
            if (MemW && (IRWrite || MemR)) bus_error <= 1'b1;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (state == RD_WAIT) begin
              if (fetch) IR  <= mem_rdata;
              else       MDR <= mem_rdata;
            end
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ir_interface.sv
// Directed and randomized transactions against a transaction-level model of the
// memory bridge (expected IR/MDR/error and stall length computed per access).
module tb_mem_ir_interface;

  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        Reset, IoD, MemR, MemW, IRWrite, mem_ack;
  logic [15:0] PC, ALUOut, WriteData, mem_rdata;
  logic [15:0] IR, MDR, mem_addr, mem_wdata;
  logic [6:0]  input_control;
  logic        Stall, bus_error, mem_req, mem_we;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_ir, m_mdr;
  logic        m_err;

  mem_ir_interface #(.DATA_W(16), .TIMEOUT(TIMEOUT), .IR_RESET(16'h0000)) dut (
    .CLK(CLK), .Reset(Reset), .IoD(IoD), .MemR(MemR), .MemW(MemW), .IRWrite(IRWrite),
    .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData), .IR(IR), .MDR(MDR),
    .input_control(input_control), .Stall(Stall), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_ir"}, IR, m_ir);
    chk({tag, "_mdr"}, MDR, m_mdr);
    chk({tag, "_err"}, bus_error, m_err);
    chk({tag, "_ictl"}, input_control, {m_ir[15:12], m_ir[2:0]});
  endtask

  task automatic clear_cmd();
    IoD = $urandom; MemR = 0; MemW = 0; IRWrite = 0;
    PC = $urandom; ALUOut = $urandom; WriteData = $urandom;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1; mem_ack = 0; clear_cmd();
    #1;
    m_ir = 16'h0000; m_mdr = 16'h0000; m_err = 1'b0;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_stall", Stall, 0);
    check_regs("rst");
    @(negedge CLK);
    Reset = 0;
  endtask

  // ack_delay: WAIT cycle (1-based) on which mem_ack is driven; beyond TIMEOUT means never.
  task automatic access(input logic iod, input logic memr, input logic memw, input logic irw,
                        input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [15:0] rd, input int ack_delay, input string tag);
    logic [15:0] exp_addr;
    bit to, done_seen;
    int n, k;
    exp_addr = iod ? alu : pc;
    to = (ack_delay > TIMEOUT);
    n  = to ? TIMEOUT : ack_delay;
    @(negedge CLK);
    IoD = iod; MemR = memr; MemW = memw; IRWrite = irw; PC = pc; ALUOut = alu; WriteData = wd;
    #1 chk({tag, "_stall_idle"}, Stall, 1);
    k = 0; done_seen = 0;
    for (int c = 0; c < TIMEOUT + 10; c++) begin
      @(negedge CLK);
      mem_ack = 0;
      if (!Stall) begin
        done_seen = 1;
        break;
      end
      k++;
      if (k == 1) begin
        chk({tag, "_req"}, mem_req, 1);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_we"}, mem_we, memw);
        chk({tag, "_wdata"}, mem_wdata, wd);
      end else if (!mem_req || mem_addr !== exp_addr) begin
        chk({tag, "_hold"}, {mem_req, mem_addr}, {1'b1, exp_addr});
      end
      clear_cmd();
      mem_rdata = $urandom;
      if (k == ack_delay) begin
        mem_ack = 1; mem_rdata = rd;
      end
    end
    chk({tag, "_done"}, done_seen, 1);
    chk({tag, "_stall_cycles"}, 1 + k, 1 + n);
    chk({tag, "_req_done"}, mem_req, 0);
    if (memw && (irw || memr)) m_err = 1'b1;
    if (to) m_err = 1'b1;
    else if (!memw) begin
      if (irw) m_ir = rd;
      else     m_mdr = rd;
    end
    check_regs(tag);
  endtask

  task automatic spurious_ack();
    @(negedge CLK);
    clear_cmd();
    mem_ack = 1; mem_rdata = $urandom;
    #1 chk("spur_stall", Stall, 0);
    @(negedge CLK);
    mem_ack = 0;
    chk("spur_req", mem_req, 0);
    check_regs("spur");
  endtask

  initial begin
    Reset = 1; mem_ack = 0; mem_rdata = 0;
    IoD = 0; MemR = 0; MemW = 0; IRWrite = 0; PC = 0; ALUOut = 0; WriteData = 0;
    m_ir = 0; m_mdr = 0; m_err = 0;
    repeat (2) @(negedge CLK);
    do_reset();

    // Fetch, load, store, exact-deadline ack
    access(0, 0, 0, 1, 16'h0010, 16'h5555, 16'h0000, 16'hB001, 1, "fetch");
    chk("fetch_ictl_lit", input_control, 7'b1011_001);
    access(1, 1, 0, 0, 16'h1111, 16'h0200, 16'h0000, 16'h1234, 4, "load");
    access(1, 0, 1, 0, 16'h2222, 16'h0300, 16'hBEEF, 16'hAAAA, 1, "store");
    access(1, 1, 0, 0, 16'h3333, 16'h0400, 16'h0000, 16'h7E57, TIMEOUT, "ack_at_limit");
    access(0, 1, 0, 1, 16'h0044, 16'h0999, 16'h0000, 16'hC3A5, 2, "fetch_memr");
    spurious_ack();

    // Timeout: no ack at all
    access(1, 1, 0, 0, 16'h0000, 16'h0500, 16'h0000, 16'hDEAD, TIMEOUT + 3, "timeout");
    spurious_ack();

    // Reset in the middle of a read, then a late ack
    do_reset();
    @(negedge CLK);
    IoD = 1; MemR = 1; ALUOut = 16'h0600;
    @(negedge CLK);
    clear_cmd();
    #2 Reset = 1;
    #1;
    m_ir = 0; m_mdr = 0; m_err = 0;
    chk("midrst_req", mem_req, 0);
    chk("midrst_stall", Stall, 0);
    check_regs("midrst");
    @(negedge CLK);
    Reset = 0;
    mem_ack = 1; mem_rdata = 16'hFACE;
    @(negedge CLK);
    mem_ack = 0;
    chk("late_ack_req", mem_req, 0);
    check_regs("late_ack");

    // Illegal write+read
    access(1, 1, 1, 0, 16'h0000, 16'h0700, 16'h1357, 16'h9999, 2, "illegal");
    spurious_ack();

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      int sel, dly;
      if (i % 10 == 0) do_reset();
      sel = $urandom_range(0, 4);
      dly = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                        : $urandom_range(1, 6);
      case (sel)
        0: access($urandom, 0, 0, 1, $urandom, $urandom, $urandom, $urandom, dly, "r_fetch");
        1: access($urandom, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, dly, "r_load");
        2: access($urandom, 0, 1, 0, $urandom, $urandom, $urandom, $urandom, dly, "r_store");
        3: access($urandom, $urandom, 1, 1, $urandom, $urandom, $urandom, $urandom, dly, "r_illegal");
        default: access($urandom, 1, 0, 1, $urandom, $urandom, $urandom, $urandom, dly, "r_fetchr");
      endcase
      if ($urandom_range(0, 3) == 0) spurious_ack();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
